// File: rtl/register_file_mp_if.sv
// Register file access bus: write port, NRD read ports, clear request and
// init status. The master drives requests; the register file is the slave.
interface register_file_mp_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 16,
  parameter int NRD    = 2
);
  localparam int NBYTE = DWIDTH / 8;

  logic                    clr;
  logic                    wr_en;
  logic [AWIDTH-1:0]       wr_addr;
  logic [DWIDTH-1:0]       wr_data;
  logic [NBYTE-1:0]        wr_be;
  logic [NRD-1:0]          rd_en;
  logic [NRD*AWIDTH-1:0]   rd_addr;
  logic [NRD*DWIDTH-1:0]   rd_data;
  logic [NRD-1:0]          rd_valid;
  logic                    init_busy;

  modport master (
    output clr, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enable writes, registered reads
// with optional write-first bypass, optional hard-wired zero entry and a
// clear sequencer that zero-fills the array after reset or on request.
module register_file_mp #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 16,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** AWIDTH;
  localparam int NBYTE = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] LAST = '1;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] cnt, cnt_next;
  logic              busy_q, busy_next;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              ready;
  logic              wr_fire;
  logic [DWIDTH-1:0] wr_old;
  logic [DWIDTH-1:0] wr_merged;

  logic [AWIDTH-1:0] rd_addr_w [NRD];
  logic [DWIDTH-1:0] rd_value  [NRD];

  logic [NRD*DWIDTH-1:0] rd_data_q;
  logic [NRD-1:0]        rd_valid_q;

  assign ready = (state == ST_READY);

  // Sequencer state, sweep counter and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= busy_next;
    end
  end

  // Sweep stops on terminal count so the counter never wraps into a second pass
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_INIT: begin
        if (cnt == LAST) begin
          state_next = ST_READY;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.clr) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
    busy_next = (state_next == ST_INIT);
  end

  // Write qualification and byte merge with the current entry contents
  always_comb begin
    wr_fire = bus.wr_en && ready;
    if ((ZERO_REG != 0) && (bus.wr_addr == '0)) begin
      wr_fire = 1'b0;
    end
    wr_old    = mem[bus.wr_addr];
    wr_merged = wr_old;
    for (int unsigned b = 0; b < NBYTE; b++) begin
      if (bus.wr_be[b]) begin
        wr_merged[b*8 +: 8] = bus.wr_data[b*8 +: 8];
      end
    end
  end

  // Array update: sweep zero-fill has priority, otherwise the merged write
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  // Per-port read value: zero entry, then write-first forward, then array
  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_addr_w[i] = bus.rd_addr[i*AWIDTH +: AWIDTH];
      if ((ZERO_REG != 0) && (rd_addr_w[i] == '0)) begin
        rd_value[i] = '0;
      end else if ((BYPASS != 0) && wr_fire && (rd_addr_w[i] == bus.wr_addr)) begin
        rd_value[i] = wr_merged;
      end else begin
        rd_value[i] = mem[rd_addr_w[i]];
      end
    end
  end

  // Registered read ports; data holds when a port is idle or during the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NRD; i++) begin
        if (ready && bus.rd_en[i]) begin
          rd_data_q[i*DWIDTH +: DWIDTH] <= rd_value[i];
          rd_valid_q[i]                 <= 1'b1;
        end else begin
          rd_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_busy = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp. Three instances share one stimulus:
// dut_a (BYPASS=1), dut_b (BYPASS=0), dut_c (BYPASS=1, ZERO_REG=1).
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clr     = 1'b0;
  logic        wr_en   = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be   = '0;
  logic [1:0]  rd_en   = '0;
  logic [9:0]  rd_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;
  int bad;
  logic [31:0] held;

  register_file_mp_if #(.AWIDTH(5), .DWIDTH(16), .NRD(2)) bus_a ();
  register_file_mp_if #(.AWIDTH(5), .DWIDTH(16), .NRD(2)) bus_b ();
  register_file_mp_if #(.AWIDTH(5), .DWIDTH(16), .NRD(2)) bus_c ();

  assign bus_a.clr = clr;     assign bus_b.clr = clr;     assign bus_c.clr = clr;
  assign bus_a.wr_en = wr_en; assign bus_b.wr_en = wr_en; assign bus_c.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr; assign bus_c.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data; assign bus_c.wr_data = wr_data;
  assign bus_a.wr_be = wr_be; assign bus_b.wr_be = wr_be; assign bus_c.wr_be = wr_be;
  assign bus_a.rd_en = rd_en; assign bus_b.rd_en = rd_en; assign bus_c.rd_en = rd_en;
  assign bus_a.rd_addr = rd_addr; assign bus_b.rd_addr = rd_addr; assign bus_c.rd_addr = rd_addr;

  register_file_mp #(.AWIDTH(5), .DWIDTH(16), .NRD(2), .BYPASS(1), .ZERO_REG(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  register_file_mp #(.AWIDTH(5), .DWIDTH(16), .NRD(2), .BYPASS(0), .ZERO_REG(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  register_file_mp #(.AWIDTH(5), .DWIDTH(16), .NRD(2), .BYPASS(1), .ZERO_REG(1))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic rd_both(input logic [4:0] a0, input logic [4:0] a1);
    rd_en = 2'b11; rd_addr = {a1, a0};
    tick();
    rd_en = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus_a.init_busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy_a", {31'd0, bus_a.init_busy}, 32'd1);
    check("rst_valid_a", {30'd0, bus_a.rd_valid}, 32'd0);
    check("rst_data_a", bus_a.rd_data, 32'h0);
    check("rst_busy_c", {31'd0, bus_c.init_busy}, 32'd1);

    // Initial sweep after reset release
    rst = 1'b0;
    count_busy(cycles);
    check("init_len", cycles, 32'd32);
    check("init_done_b", {31'd0, bus_b.init_busy}, 32'd0);
    check("init_done_c", {31'd0, bus_c.init_busy}, 32'd0);

    // Every entry reads zero on both ports
    for (int a = 0; a < 32; a++) begin
      rd_both(a[4:0], a[4:0]);
      check("zero_valid", {30'd0, bus_a.rd_valid}, 32'd3);
      check("zero_data", bus_a.rd_data, 32'h0);
    end
    tick();
    check("valid_drop", {30'd0, bus_a.rd_valid}, 32'd0);

    // Byte-enable merge, read on port 1
    wr(5'd3, 16'hABCD, 2'b11);
    wr(5'd3, 16'h1200, 2'b10);
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    check("be_pre_valid", {30'd0, bus_a.rd_valid}, 32'd0);
    tick();
    rd_en = '0;
    check("be_valid", {30'd0, bus_a.rd_valid}, 32'd2);
    check("be_data_a", {16'd0, bus_a.rd_data[31:16]}, 32'h12CD);
    check("be_data_b", {16'd0, bus_b.rd_data[31:16]}, 32'h12CD);
    check("be_data_c", {16'd0, bus_c.rd_data[31:16]}, 32'h12CD);
    tick();
    check("hold_valid", {30'd0, bus_a.rd_valid}, 32'd0);
    check("hold_data", {16'd0, bus_a.rd_data[31:16]}, 32'h12CD);

    // Same-cycle write and read: bypass vs. pre-write contents
    wr(5'd7, 16'h0001, 2'b11);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'h5555; wr_be = 2'b11;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = '0;
    check("byp_a", {16'd0, bus_a.rd_data[15:0]}, 32'h5555);
    check("byp_b", {16'd0, bus_b.rd_data[15:0]}, 32'h0001);
    check("byp_c", {16'd0, bus_c.rd_data[15:0]}, 32'h5555);
    rd_en = 2'b01; tick(); rd_en = '0;
    check("after_a", {16'd0, bus_a.rd_data[15:0]}, 32'h5555);
    check("after_b", {16'd0, bus_b.rd_data[15:0]}, 32'h5555);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'h00AA; wr_be = 2'b01;
    rd_en = 2'b01;
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = '0;
    check("byp_part_a", {16'd0, bus_a.rd_data[15:0]}, 32'h55AA);
    check("byp_part_b", {16'd0, bus_b.rd_data[15:0]}, 32'h5555);

    // Hard-wired zero entry
    wr(5'd0, 16'hFFFF, 2'b11);
    wr(5'd1, 16'hFFFF, 2'b11);
    rd_both(5'd0, 5'd0);
    check("zr_c", bus_c.rd_data, 32'h0);
    check("zr_a", bus_a.rd_data, 32'hFFFF_FFFF);
    rd_both(5'd1, 5'd1);
    check("zr_one_c", bus_c.rd_data, 32'hFFFF_FFFF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h1111; wr_be = 2'b11;
    rd_en = 2'b01; rd_addr = '0;
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = '0;
    check("zr_byp_c", {16'd0, bus_c.rd_data[15:0]}, 32'h0);
    check("zr_byp_a", {16'd0, bus_a.rd_data[15:0]}, 32'h1111);

    // Clear request; the read issued with clr is still served
    wr(5'd5, 16'h1234, 2'b11);
    clr = 1'b1; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    clr = 1'b0; rd_en = '0;
    check("clr_rd_valid", {30'd0, bus_a.rd_valid}, 32'd1);
    check("clr_rd_data", {16'd0, bus_a.rd_data[15:0]}, 32'h1234);
    check("clr_busy", {31'd0, bus_a.init_busy}, 32'd1);
    held = bus_a.rd_data;
    cycles = 0; bad = 0;
    while (bus_a.init_busy && cycles < 100) begin
      if (cycles >= 1 && (bus_a.rd_valid != 2'b00 || bus_a.rd_data != held)) bad++;
      if (cycles == 20) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'hBEEF; wr_be = 2'b11;
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
      end else begin
        wr_en = 1'b0; wr_be = '0; rd_en = '0;
      end
      cycles++;
      tick();
    end
    wr_en = 1'b0; wr_be = '0; rd_en = '0;
    check("clr_len", cycles, 32'd32);
    check("clr_quiet", bad, 32'd0);
    rd_both(5'd5, 5'd3);
    check("clr_zero_a", bus_a.rd_data, 32'h0);
    check("clr_zero_b", bus_b.rd_data, 32'h0);
    check("clr_zero_c", bus_c.rd_data, 32'h0);

    // Reset mid-sweep restarts a full sweep
    wr(5'd2, 16'h4321, 2'b11);
    rd_both(5'd2, 5'd2);
    check("pre_rst_data", bus_a.rd_data, 32'h4321_4321);
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (10) tick();
    check("mid_busy", {31'd0, bus_a.init_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_busy", {31'd0, bus_a.init_busy}, 32'd1);
    check("async_data", bus_a.rd_data, 32'h0);
    check("async_valid", {30'd0, bus_a.rd_valid}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd2, 5'd2};
    cycles = 0; bad = 0;
    while (bus_a.init_busy && cycles < 100) begin
      if (bus_a.rd_valid != 2'b00 || bus_a.rd_data != 32'h0) bad++;
      cycles++;
      tick();
    end
    rd_en = '0;
    check("rst_len", cycles, 32'd32);
    check("rst_quiet", bad, 32'd0);
    rd_both(5'd2, 5'd3);
    check("rst_zero_valid", {30'd0, bus_a.rd_valid}, 32'd3);
    check("rst_zero_data", bus_a.rd_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
